// File: rtl/frame_capture_if.sv
// Pixel-stream sink, status and buffer read-port bundle for frame_capture.
// The master drives pixels, clear and read requests; the slave returns data and status.
interface frame_capture_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10
);
    logic [DATA_W-1:0] grayscale_i;
    logic              done_i;
    logic              clear_i;
    logic              rd_en_i;
    logic [ADDR_W-1:0] rd_addr_i;
    logic [DATA_W-1:0] rd_data_o;
    logic              rd_valid_o;
    logic              busy_o;
    logic              frame_done_o;
    logic              short_o;
    logic              overflow_o;
    logic [ADDR_W-1:0] pixel_count_o;
    logic [ADDR_W-1:0] row_o;
    logic [ADDR_W-1:0] col_o;

    modport master (
        output grayscale_i, done_i, clear_i, rd_en_i, rd_addr_i,
        input  rd_data_o, rd_valid_o, busy_o, frame_done_o, short_o, overflow_o,
        input  pixel_count_o, row_o, col_o
    );

    modport slave (
        input  grayscale_i, done_i, clear_i, rd_en_i, rd_addr_i,
        output rd_data_o, rd_valid_o, busy_o, frame_done_o, short_o, overflow_o,
        output pixel_count_o, row_o, col_o
    );
endinterface

// File: rtl/frame_capture.sv
// Captures one WIDTH x HEIGHT raster frame into a buffer, tracks position and
// flags complete/short/overflowing frames; registered random-access read port.
module frame_capture #(
    parameter int DATA_W = 8,
    parameter int WIDTH  = 30,
    parameter int HEIGHT = 30,
    parameter int ADDR_W = 10
) (
    input  logic           clk,
    input  logic           rst,
    frame_capture_if.slave fc
);
    localparam int                FRAME_PIX   = WIDTH * HEIGHT;
    localparam int                DEPTH       = 32'sd1 <<< ADDR_W;
    localparam logic [ADDR_W-1:0] FRAME_PIX_A = ADDR_W'(FRAME_PIX);
    localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(FRAME_PIX - 32'sd1);
    localparam logic [ADDR_W-1:0] COL_LAST    = ADDR_W'(WIDTH - 32'sd1);
    localparam logic [ADDR_W-1:0] ZERO_A      = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ONE_A       = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    state_t            state_r, state_next_s;
    logic              wr_en_s, last_pix_s;
    logic [ADDR_W-1:0] count_r, row_r, col_r;
    logic [ADDR_W-1:0] count_next_s, row_next_s, col_next_s;
    logic              busy_r, frame_done_r, short_r, overflow_r;
    logic              busy_next_s, frame_done_next_s, short_next_s, overflow_next_s;
    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [DATA_W-1:0] rd_data_r;
    logic              rd_valid_r;

    // IDLE has count 0, so the write address is always the running count.
    assign wr_en_s    = !rst && fc.done_i && !fc.clear_i &&
                        ((state_r == ST_IDLE) || (state_r == ST_CAPTURE));
    assign last_pix_s = (count_r == LAST_ADDR);

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state decode; clear_i overrides everything
    always_comb begin
        state_next_s = state_r;
        if (fc.clear_i) begin
            state_next_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (fc.done_i) begin
                        state_next_s = last_pix_s ? ST_DONE : ST_CAPTURE;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end
                ST_CAPTURE: begin
                    if (!fc.done_i || last_pix_s) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_CAPTURE;
                    end
                end
                ST_DONE:  state_next_s = ST_DONE;
                default:  state_next_s = ST_IDLE;
            endcase
        end
    end

    // Next values of counters, position and status flags
    always_comb begin
        count_next_s      = count_r;
        row_next_s        = row_r;
        col_next_s        = col_r;
        busy_next_s       = (state_next_s == ST_CAPTURE);
        frame_done_next_s = (state_next_s == ST_DONE);
        short_next_s      = short_r;
        overflow_next_s   = overflow_r;
        if (fc.clear_i) begin
            count_next_s    = ZERO_A;
            row_next_s      = ZERO_A;
            col_next_s      = ZERO_A;
            short_next_s    = 1'b0;
            overflow_next_s = 1'b0;
        end else begin
            if (wr_en_s) begin
                count_next_s = count_r + ONE_A;
                if (col_r == COL_LAST) begin
                    col_next_s = ZERO_A;
                    row_next_s = row_r + ONE_A;
                end else begin
                    col_next_s = col_r + ONE_A;
                    row_next_s = row_r;
                end
            end else begin
                count_next_s = count_r;
            end
            if ((state_r == ST_CAPTURE) && !fc.done_i) begin
                short_next_s = 1'b1;
            end else begin
                short_next_s = short_r;
            end
            if ((state_r == ST_DONE) && fc.done_i) begin
                overflow_next_s = 1'b1;
            end else begin
                overflow_next_s = overflow_r;
            end
        end
    end

    // Status and position registers
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r      <= ZERO_A;
            row_r        <= ZERO_A;
            col_r        <= ZERO_A;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
            short_r      <= 1'b0;
            overflow_r   <= 1'b0;
        end else begin
            count_r      <= count_next_s;
            row_r        <= row_next_s;
            col_r        <= col_next_s;
            busy_r       <= busy_next_s;
            frame_done_r <= frame_done_next_s;
            short_r      <= short_next_s;
            overflow_r   <= overflow_next_s;
        end
    end

    // Frame buffer write; contents survive reset and clear
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[count_r] <= fc.grayscale_i;
        end
    end

    // Registered read port; same-edge write is not yet visible (read-first)
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_r  <= {DATA_W{1'b0}};
            rd_valid_r <= 1'b0;
        end else begin
            rd_valid_r <= fc.rd_en_i;
            if (fc.rd_en_i) begin
                rd_data_r <= (fc.rd_addr_i >= FRAME_PIX_A) ? {DATA_W{1'b0}} : mem_r[fc.rd_addr_i];
            end
        end
    end

    assign fc.rd_data_o     = rd_data_r;
    assign fc.rd_valid_o    = rd_valid_r;
    assign fc.busy_o        = busy_r;
    assign fc.frame_done_o  = frame_done_r;
    assign fc.short_o       = short_r;
    assign fc.overflow_o    = overflow_r;
    assign fc.pixel_count_o = count_r;
    assign fc.row_o         = row_r;
    assign fc.col_o         = col_r;
endmodule
